// File: rtl/ecat_pkt_fifo_if.sv
// ============================================================================
// ecat_pkt_fifo_if : writer/reader bus for the ecat_pkt_fifo packet FIFO
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface ecat_pkt_fifo_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9
) ();
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_commit;
  logic                  wr_discard;
  logic                  full;
  logic                  afull;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   level;
  logic [15:0]           drop_cnt;

  modport master (
    output wr_en, wr_data, wr_commit, wr_discard, rd_en,
    input  full, afull, rd_data, rd_valid, level, drop_cnt
  );

  modport slave (
    input  wr_en, wr_data, wr_commit, wr_discard, rd_en,
    output full, afull, rd_data, rd_valid, level, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ecat_pkt_fifo.sv
// ============================================================================
// ecat_pkt_fifo : single-clock commit/discard packet FIFO, FWFT read side.
// Optional drop counter: define ECAT_PKT_FIFO_STATS_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ecat_pkt_fifo #(
  parameter int DATA_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 16
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  ecat_pkt_fifo_if.slave   bus
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_P   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   cptr_q, cptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic                  ovf_q, ovf_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [ADDR_WIDTH:0]   used;
  logic [ADDR_WIDTH:0]   wptr_nxt;
  logic                  full;
  logic                  wr_do;
  logic                  wr_ovf;
  logic                  pop;
  logic                  fetch;

  assign used   = wptr_q - rptr_q;
  assign full   = (used == DEPTH_P);
  assign wr_ovf = bus.wr_en && full;
  assign wr_do  = bus.wr_en && !full && !bus.wr_discard;
  assign pop    = bus.rd_en && rd_valid_q;
  // The output register doubles as the RAM read register, so a pop and a
  // refill can share one cycle and sustain one word per clock.
  assign fetch  = (rptr_q != cptr_q) && (!rd_valid_q || pop);

  always_comb begin
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    ovf_d      = ovf_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    wptr_nxt   = wptr_q + (ADDR_WIDTH+1)'(wr_do);
    level_d    = cptr_q - rptr_q + {{ADDR_WIDTH{1'b0}}, rd_valid_q};

    if (bus.wr_discard) begin
      wptr_d = cptr_q;
      ovf_d  = 1'b0;
    end else if (bus.wr_commit) begin
      ovf_d = 1'b0;
      if (ovf_q || wr_ovf) begin
        wptr_d = cptr_q;
      end else begin
        // An empty frame leaves wptr_nxt == cptr_q, so this is a no-op.
        wptr_d = wptr_nxt;
        cptr_d = wptr_nxt;
      end
    end else begin
      wptr_d = wptr_nxt;
      if (wr_ovf) ovf_d = 1'b1;
    end

    if (fetch) begin
      rptr_d     = rptr_q + 1'b1;
      rd_valid_d = 1'b1;
    end else if (pop) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      level_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      cptr_q     <= cptr_d;
      rptr_q     <= rptr_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_do) mem[wptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (fetch) begin
      rd_data_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
    end
  end

`ifdef ECAT_PKT_FIFO_STATS_EN
  logic        drop_inc;
  logic [15:0] drop_q, drop_d;

  assign drop_inc = bus.wr_commit && !bus.wr_discard && (ovf_q || wr_ovf);

  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) drop_q <= '0;
    else          drop_q <= drop_d;
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.full     = full;
  assign bus.afull    = (used >= AFULL_LVL);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.level    = level_q;

endmodule

`default_nettype wire

// File: tb/tb_ecat_pkt_fifo.sv
// ============================================================================
// tb_ecat_pkt_fifo : directed self-checking bench, DEPTH=16, AFULL_THRESH=12
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecat_pkt_fifo;

  localparam int DW    = 36;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

`ifdef ECAT_PKT_FIFO_STATS_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic clock;
  logic reset_n;
  int   tests;
  int   fails;

  ecat_pkt_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ecat_pkt_fifo #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (12)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.wr_commit  = 1'b0;
    bus.wr_discard = 1'b0;
    bus.rd_en      = 1'b0;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    tick(); tick();
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %0b want 0", bus.rd_valid); end
    tests++; if (bus.rd_data !== 36'h0) begin fails++; $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); end
    tests++; if (bus.level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", bus.level); end
    tests++; if (bus.drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop got %0d want 0", bus.drop_cnt); end
    tests++; if ({bus.full, bus.afull} !== 2'b00) begin fails++; $display("FAIL reset_flags got %0b want 00", {bus.full, bus.afull}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_commit_latency();
    for (int i = 1; i <= 4; i++) write_word(36'(i));
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL uncommitted_visible got %0b want 0", bus.rd_valid); end
    commit();
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL latency_n1 got %0b want 0", bus.rd_valid); end
    tick();
    tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL latency_n2 got %0b want 1", bus.rd_valid); end
    tests++; if (bus.rd_data !== 36'h1) begin fails++; $display("FAIL first_word got %0h want 1", bus.rd_data); end
    tests++; if (bus.level !== 5'd4) begin fails++; $display("FAIL level4 got %0d want 4", bus.level); end
    bus.rd_en = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      tests++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 36'(i)}) begin fails++; $display("FAIL b2b_pop got v=%0b d=%0h want v=1 d=%0h", bus.rd_valid, bus.rd_data, i); end
    end
    tick();
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL drained got %0b want 0", bus.rd_valid); end
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_discard();
    logic [DW-1:0] got [$];
    logic [AW:0]   peak;
    peak = '0;
    for (int i = 7; i <= 9; i++) write_word(36'(i));
    bus.wr_discard = 1'b1;
    tick();
    bus.wr_discard = 1'b0;
    write_word(36'hA);
    write_word(36'hB);
    commit();
    bus.rd_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.level > peak) peak = bus.level;
      if (bus.rd_valid) got.push_back(bus.rd_data);
      tick();
    end
    bus.rd_en = 1'b0;
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL discard_count got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      tests++; if ({got[0], got[1]} !== {36'hA, 36'hB}) begin fails++; $display("FAIL discard_data got %0h,%0h want a,b", got[0], got[1]); end
    end
    tests++; if (peak !== 5'd2) begin fails++; $display("FAIL discard_peak got %0d want 2", peak); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 16; i++) begin
      write_word(36'(i + 'h40));
      if (i == 11) begin
        tests++; if (bus.afull !== 1'b0) begin fails++; $display("FAIL afull_11 got %0b want 0", bus.afull); end
      end
      if (i == 12) begin
        tests++; if (bus.afull !== 1'b1) begin fails++; $display("FAIL afull_12 got %0b want 1", bus.afull); end
      end
      if (i == 15) begin
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL full_15 got %0b want 0", bus.full); end
      end
    end
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL full_16 got %0b want 1", bus.full); end
    write_word(36'h77);
    commit();
    tests++; if ({bus.full, bus.afull} !== 2'b00) begin fails++; $display("FAIL ovf_rewind got %0b want 00", {bus.full, bus.afull}); end
    tick(); tick();
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL ovf_visible got %0b want 0", bus.rd_valid); end
    tests++; if (bus.level !== 5'd0) begin fails++; $display("FAIL ovf_level got %0d want 0", bus.level); end
    tests++; if (bus.drop_cnt !== EXP_DROP) begin fails++; $display("FAIL drop_cnt got %0d want %0d", bus.drop_cnt, EXP_DROP); end
  endtask

  task automatic test_commit_discard();
    for (int i = 0; i < 5; i++) write_word(36'(i + 'h60));
    bus.wr_commit  = 1'b1;
    bus.wr_discard = 1'b1;
    tick();
    bus.wr_commit  = 1'b0;
    bus.wr_discard = 1'b0;
    tick(); tick();
    tests++; if ({bus.rd_valid, bus.level} !== 6'd0) begin fails++; $display("FAIL cd_visible got v=%0b l=%0d want 0", bus.rd_valid, bus.level); end
    tests++; if (bus.drop_cnt !== EXP_DROP) begin fails++; $display("FAIL cd_drop got %0d want %0d", bus.drop_cnt, EXP_DROP); end
    // A single follow-up word must be the only thing visible.
    bus.wr_en     = 1'b1;
    bus.wr_data   = 36'h55;
    bus.wr_commit = 1'b1;
    tick();
    idle();
    tick(); tick();
    tests++; if ({bus.rd_valid, bus.rd_data, bus.level} !== {1'b1, 36'h55, 5'd1}) begin fails++; $display("FAIL cd_next got v=%0b d=%0h l=%0d want v=1 d=55 l=1", bus.rd_valid, bus.rd_data, bus.level); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL cd_drain got %0b want 0", bus.rd_valid); end
  endtask

  task automatic test_traffic();
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] pend_q [$];
    int sent, recv, outstanding, flen, fcnt, cyc, bad_full;
    sent = 0; recv = 0; outstanding = 0; fcnt = 0; cyc = 0; bad_full = 0;
    flen = $urandom_range(1, 5);
    while ((recv < 3*DEPTH) && (cyc < 4000)) begin
      idle();
      if (bus.full && (outstanding < DEPTH)) bad_full++;
      bus.rd_en = 1'($urandom_range(0, 1));
      if (bus.rd_en && bus.rd_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL traffic_extra got %0h want none", bus.rd_data);
        end else begin
          if (bus.rd_data !== exp_q[0]) begin fails++; $display("FAIL traffic_data got %0h want %0h", bus.rd_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        recv++;
        outstanding--;
      end
      if ((sent < 3*DEPTH) && !bus.full) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 36'(sent + 'h100);
        pend_q.push_back(36'(sent + 'h100));
        sent++; fcnt++; outstanding++;
        if ((fcnt == flen) || (sent == 3*DEPTH)) begin
          bus.wr_commit = 1'b1;
          while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
          fcnt = 0;
          flen = $urandom_range(1, 5);
        end
      end
      tick();
      cyc++;
    end
    idle();
    tests++; if (recv !== 3*DEPTH) begin fails++; $display("FAIL traffic_count got %0d want %0d", recv, 3*DEPTH); end
    tests++; if (bad_full !== 0) begin fails++; $display("FAIL traffic_full got %0d spurious want 0", bad_full); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) write_word(36'(i + 'h20));
    commit();
    tick();
    write_word(36'h2E);
    write_word(36'h2F);
    tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL rst_pre got %0b want 1", bus.rd_valid); end
    reset_n = 1'b0;
    #1;
    tests++; if ({bus.rd_valid, bus.rd_data, bus.level, bus.full, bus.afull} !== '0) begin fails++; $display("FAIL rst_async got v=%0b d=%0h l=%0d want 0", bus.rd_valid, bus.rd_data, bus.level); end
    tests++; if (bus.drop_cnt !== 16'd0) begin fails++; $display("FAIL rst_drop got %0d want 0", bus.drop_cnt); end
    tick();
    reset_n = 1'b1;
    tick();
    write_word(36'h31);
    write_word(36'h32);
    commit();
    tick();
    tests++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 36'h31}) begin fails++; $display("FAIL rst_new0 got v=%0b d=%0h want v=1 d=31", bus.rd_valid, bus.rd_data); end
    bus.rd_en = 1'b1;
    tick();
    tests++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 36'h32}) begin fails++; $display("FAIL rst_new1 got v=%0b d=%0h want v=1 d=32", bus.rd_valid, bus.rd_data); end
    tick();
    bus.rd_en = 1'b0;
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rst_drain got %0b want 0", bus.rd_valid); end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    idle();
    test_reset();
    test_commit_latency();
    test_discard();
    test_overflow();
    test_commit_discard();
    test_traffic();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
